rect_frame_scheduler: RTL

Configuration scheduler and pixel compositor for the bank of rectangle draw units. Game or control logic writes rectangle descriptors (limits, color, enable) over a valid/ready port. The block buffers them in shadow registers and commits them to the live draw-unit inputs only at a fixed point in vertical blanking, so no frame is ever drawn with half-updated geometry. It also merges the draw units' 12-bit pixel outputs into one priority-ordered pixel stream for the VGA output stage.

---
 rtl/vga_draw_pkg.sv | 40 ++++
 rtl/rect_frame_scheduler_if.sv | 30 +++
 rtl/rect_priority_mux.sv | 21 ++
 rtl/rect_frame_scheduler.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// Shared VGA drawing types and constants: timing limits, color codes,
// scheduler states and the rectangle descriptor payload.
package vga_draw_pkg;

   localparam int unsigned POS_W          = 16;
   localparam int unsigned RGB_W          = 12;
   localparam int unsigned COLOR_W        = 3;
   localparam int unsigned H_ACTIVE_START = 144;
   localparam int unsigned H_ACTIVE_END   = 783;
   localparam int unsigned V_ACTIVE_START = 35;
   localparam int unsigned V_ACTIVE_END   = 514;
   localparam int unsigned H_TOTAL        = 800;

   localparam logic [COLOR_W-1:0] BLACK = 3'd0;
   localparam logic [COLOR_W-1:0] RED   = 3'd1;
   localparam logic [COLOR_W-1:0] GREEN = 3'd2;
   localparam logic [COLOR_W-1:0] BLUE  = 3'd3;
   localparam logic [COLOR_W-1:0] WHITE = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [POS_W-1:0]   hstart;
      logic [POS_W-1:0]   hend;
      logic [POS_W-1:0]   vstart;
      logic [POS_W-1:0]   vend;
      logic [COLOR_W-1:0] color;
      logic               enable;
   } rect_desc_t;

   // Geometry or color that a draw unit cannot render sensibly.
   function automatic logic desc_invalid(input rect_desc_t d);
      return (d.hstart > d.hend) || (d.vstart > d.vend) || (d.color > WHITE);
   endfunction

endpackage

// File: rtl/rect_frame_scheduler_if.sv
// Rectangle descriptor write port: valid/ready handshake plus error pulse.
interface rect_frame_scheduler_if #(
   parameter int unsigned SLOT_W = 3
);
   import vga_draw_pkg::*;

   logic               cfg_valid;
   logic               cfg_ready;
   logic [SLOT_W-1:0]  cfg_slot;
   logic [POS_W-1:0]   cfg_hstart;
   logic [POS_W-1:0]   cfg_hend;
   logic [POS_W-1:0]   cfg_vstart;
   logic [POS_W-1:0]   cfg_vend;
   logic [COLOR_W-1:0] cfg_color;
   logic               cfg_enable;
   logic               cfg_err;

   modport master (
      output cfg_valid, cfg_slot, cfg_hstart, cfg_hend, cfg_vstart, cfg_vend,
             cfg_color, cfg_enable,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_slot, cfg_hstart, cfg_hend, cfg_vstart, cfg_vend,
             cfg_color, cfg_enable,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/rect_priority_mux.sv
// Combinational compositor: picks the lowest-index draw unit with a nonzero pixel.
module rect_priority_mux
   import vga_draw_pkg::*;
#(
   parameter int unsigned NUM_RECTS = 4
) (
   input  logic [NUM_RECTS*RGB_W-1:0] rect_pixel,
   output logic [RGB_W-1:0]           pixel_c
);

   // Scan high to low so the lowest nonzero slot is the last assignment.
   always_comb begin
      pixel_c = '0;
      for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
         if (rect_pixel[i*RGB_W +: RGB_W] != '0) begin
            pixel_c = rect_pixel[i*RGB_W +: RGB_W];
         end
      end
   end

endmodule

// File: rtl/rect_frame_scheduler.sv
// Shadow/live rectangle configuration with a vertical-blanking commit point,
// plus the registered priority compositor for the draw-unit pixel bank.
module rect_frame_scheduler
   import vga_draw_pkg::*;
#(
   parameter int unsigned NUM_RECTS   = 4,
   parameter int unsigned SLOT_W      = 3,
   parameter int unsigned COMMIT_LINE = 515
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [POS_W-1:0]             horizontal_actual_position,
   input  logic [POS_W-1:0]             vertical_actual_position,
   rect_frame_scheduler_if.slave        cfg,
   output logic                         pending,
   output logic                         commit_pulse,
   output logic [NUM_RECTS*POS_W-1:0]   rect_hstart,
   output logic [NUM_RECTS*POS_W-1:0]   rect_hend,
   output logic [NUM_RECTS*POS_W-1:0]   rect_vstart,
   output logic [NUM_RECTS*POS_W-1:0]   rect_vend,
   output logic [NUM_RECTS*COLOR_W-1:0] rect_color,
   output logic [NUM_RECTS-1:0]         rect_hide,
   input  logic [NUM_RECTS*RGB_W-1:0]   rect_pixel,
   output logic [RGB_W-1:0]             pixel_out
);

   sched_state_e           state, state_next;
   rect_desc_t             shadow [NUM_RECTS];
   rect_desc_t             wr_desc;
   logic [NUM_RECTS-1:0]   dirty, dirty_next;
   logic                   wr_fire, wr_bad, wr_ok, at_commit_point;
   logic                   ready_next, commit_next;
   logic [RGB_W-1:0]       pixel_c;

   assign wr_desc = '{hstart: cfg.cfg_hstart, hend: cfg.cfg_hend,
                      vstart: cfg.cfg_vstart, vend: cfg.cfg_vend,
                      color:  cfg.cfg_color,  enable: cfg.cfg_enable};

   assign wr_fire = cfg.cfg_valid && cfg.cfg_ready;
   assign wr_bad  = (32'(cfg.cfg_slot) >= NUM_RECTS) || desc_invalid(wr_desc);
   assign wr_ok   = wr_fire && !wr_bad;

   assign at_commit_point = (vertical_actual_position == POS_W'(COMMIT_LINE)) &&
                            (horizontal_actual_position == '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state: a write landing in IDLE defers the commit to the next frame.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (wr_ok) state_next = PENDING;
         PENDING: if (at_commit_point) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode, registered below.
   always_comb begin
      ready_next  = 1'b1;
      commit_next = 1'b0;
      if (state_next == COMMIT) ready_next  = 1'b0;
      if (state == COMMIT)      commit_next = 1'b1;
   end

   always_comb begin
      dirty_next = dirty;
      if (state == COMMIT) dirty_next = '0;
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
         if (wr_ok && (32'(cfg.cfg_slot) == i)) dirty_next[i] = 1'b1;
      end
   end

   // Shadow descriptors and dirty tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty <= '0;
         for (int unsigned i = 0; i < NUM_RECTS; i++) shadow[i] <= '0;
      end else begin
         dirty <= dirty_next;
         for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            if (wr_ok && (32'(cfg.cfg_slot) == i)) shadow[i] <= wr_desc;
         end
      end
   end

   // Live draw-unit inputs only change in the COMMIT cycle, and only for dirty slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rect_hstart <= '0;
         rect_hend   <= '0;
         rect_vstart <= '0;
         rect_vend   <= '0;
         rect_color  <= '0;
         rect_hide   <= '1;
      end else if (state == COMMIT) begin
         for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            if (dirty[i]) begin
               rect_hstart[i*POS_W +: POS_W]     <= shadow[i].hstart;
               rect_hend[i*POS_W +: POS_W]       <= shadow[i].hend;
               rect_vstart[i*POS_W +: POS_W]     <= shadow[i].vstart;
               rect_vend[i*POS_W +: POS_W]       <= shadow[i].vend;
               rect_color[i*COLOR_W +: COLOR_W]  <= shadow[i].color;
               rect_hide[i]                      <= ~shadow[i].enable;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg.cfg_ready <= 1'b1;
         cfg.cfg_err   <= 1'b0;
         pending       <= 1'b0;
         commit_pulse  <= 1'b0;
         pixel_out     <= '0;
      end else begin
         cfg.cfg_ready <= ready_next;
         cfg.cfg_err   <= wr_fire && wr_bad;
         pending       <= |dirty_next;
         commit_pulse  <= commit_next;
         pixel_out     <= pixel_c;
      end
   end

   rect_priority_mux #(.NUM_RECTS(NUM_RECTS)) u_mux (
      .rect_pixel (rect_pixel),
      .pixel_c    (pixel_c)
   );

endmodule
